// File: rtl/inst_sram_resp.sv
`timescale 1ns/1ps
// inst_sram_resp: single-cycle instruction SRAM responder with kseg0/kseg1
// translation, out-of-window error logging and a handshaked preload port.
module inst_sram_resp #(
    parameter int unsigned ADDR_W = 12,
    parameter logic [31:0] BASE   = 32'h1fc0_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sram_en,
    input  logic [3:0]        sram_wen,
    input  logic [31:0]       sram_addr,
    input  logic [31:0]       sram_wdata,
    output logic [31:0]       sram_rdata,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_done,
    output logic [ADDR_W:0]   ld_count,
    output logic              err_valid,
    output logic [31:0]       err_addr,
    output logic [15:0]       err_cnt
);

    localparam int unsigned   DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LD_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        LOAD,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]       mem [0:DEPTH-1];
    logic [31:2]       pa;
    logic              hit;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       wmask;
    logic              ld_fire;
    logic              unused_addr_bits;

    // Byte offset within a word plays no part in a word-organised access.
    assign unused_addr_bits = ^sram_addr[1:0];

    // kseg0/kseg1 to physical translation, window decode and byte-lane mask.
    always_comb begin
        pa = sram_addr[31:2];
        if (sram_addr[31:30] == 2'b10) begin
            pa[31:29] = 3'b000;
        end
        hit   = (pa[31:ADDR_W+2] == BASE[31:ADDR_W+2]);
        idx   = pa[ADDR_W+1:2];
        wmask = {{8{sram_wen[3]}}, {8{sram_wen[2]}}, {8{sram_wen[1]}}, {8{sram_wen[0]}}};
    end

    // Preload FSM next state and handshake outputs; the CPU always wins the port.
    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        ld_done    = 1'b0;
        ld_fire    = 1'b0;
        case (state)
            LOAD: begin
                ld_ready = !sram_en && !reset;
                ld_fire  = ld_valid && ld_ready;
                if (ld_fire && ld_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ld_done = 1'b1;
            end
            default: state_next = LOAD;
        endcase
    end

    // Preload FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Memory array: CPU byte-lane writes or full-word preload writes, never both.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sram_en && hit && (sram_wen != 4'b0000)) begin
                mem[idx] <= (mem[idx] & ~wmask) | (sram_wdata & wmask);
            end else if (ld_fire) begin
                mem[ld_addr] <= ld_data;
            end
        end
    end

    // Read data: old word on hits (read-before-write), zero on misses, held when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sram_rdata <= '0;
        end else if (sram_en) begin
            sram_rdata <= hit ? mem[idx] : '0;
        end
    end

    // Saturating count of accepted preload words.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_count <= '0;
        end else if (ld_fire && (ld_count != LD_MAX)) begin
            ld_count <= ld_count + 1'b1;
        end
    end

    // Out-of-window access logging; the address updates even once the count saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_cnt   <= '0;
        end else if (sram_en && !hit) begin
            err_valid <= 1'b1;
            err_addr  <= sram_addr;
            if (err_cnt != 16'hffff) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/inst_sram_resp.md
# inst_sram_resp

Responder side of the single-cycle instruction SRAM interface driven by the fetch stage. It is a word-organised on-chip memory with one-cycle read latency and byte-lane writes. It translates kseg0/kseg1 virtual addresses to physical addresses and answers accesses outside its window with zero data while logging an error. A handshaked preload port fills the memory before the CPU is released; the system holds the CPU in reset until `ld_done` is high.

## Interface
- `ADDR_W`, default 12: word-index width. Memory holds 2^ADDR_W words.
- `BASE`, default 32'h1fc0_0000: physical base address. It must be aligned to 2^(ADDR_W+2).
- Clocking and reset (already decided): reset `reset`, synchronous, active-high; clock `clk`.
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `sram_en`  in  1  access request this cycle
- `sram_wen`  in  4  byte write enables; 0 means read
- `sram_addr`  in  32  byte address (virtual)
- `sram_wdata`  in  32  write data
- `sram_rdata`  out  32  read data, valid the cycle after an access
- `ld_valid`  in  1  preload word offered
- `ld_ready`  out  1  preload word accepted when `ld_valid & ld_ready`
- `ld_addr`  in  ADDR_W  preload word index
- `ld_data`  in  32  preload word
- `ld_last`  in  1  final preload word
- `ld_done`  out  1  preload complete
- `ld_count`  out  ADDR_W+1  words accepted, saturating
- `err_valid`  out  1  sticky: at least one out-of-window access
- `err_addr`  out  32  `sram_addr` of the most recent out-of-window access
- `err_cnt`  out  16  out-of-window access count, saturating at 16'hffff

## Operation
- Address translation:
  - If `sram_addr[31:30]==2'b10`, then `pa = {3'b000, sram_addr[28:0]}`.
  - Otherwise `pa = sram_addr`.
- Window check:
  - `hit = (pa[31:ADDR_W+2] == BASE[31:ADDR_W+2])`.
  - `idx = pa[ADDR_W+1:2]`.
  - `sram_addr[1:0]` is ignored.
- Access when `sram_en=1`:
  - **Hit, `wen=0`:** `sram_rdata <= mem[idx]`.
  - **Hit, `wen!=0`:** for each set bit i, byte i of `mem[idx]` gets byte i of `sram_wdata`. `sram_rdata <= old mem[idx]` (read-before-write).
  - **Miss:** no memory change. `sram_rdata <= 0`. `err_valid <= 1`, `err_addr <= sram_addr`, `err_cnt` increments (saturating).
- When `sram_en=0`, `sram_rdata` holds its previous value.
- Preload FSM, states LOAD and DONE:
  - Reset enters LOAD.
  - In LOAD, `ld_ready = !sram_en`; the CPU has priority.
  - On handshake: `mem[ld_addr] <= ld_data` (full word) and `ld_count` increments (saturating at 2^ADDR_W).
  - A handshake with `ld_last=1` moves the FSM to DONE.
  - In DONE: `ld_ready=0`, `ld_done=1`, and `ld_valid` is ignored.
- A preload write and a CPU access never happen in the same cycle.
- Memory contents are not cleared by reset. Only registers reset.

## Timing
- Reset values:
  - `sram_rdata=0`, `ld_ready=0` in the reset cycle, `ld_done=0`, `ld_count=0`.
  - `err_valid=0`, `err_addr=0`, `err_cnt=0`.
  - FSM = LOAD.
- Read latency is exactly 1 cycle: access presented in cycle N, data on `sram_rdata` in N+1. Back-to-back accesses every cycle are supported.
- Write in cycle N followed by a read of the same word in N+1 returns the new data in N+2.
- Preload write in cycle N is visible to a CPU read issued in N+1.
- `ld_ready` is combinational from `sram_en` and FSM state. `ld_valid` must not depend on `ld_ready`.
- Error registers update at the end of the miss cycle. A miss in the same cycle as saturation leaves `err_cnt` at 16'hffff but still updates `err_addr`.
- Reset mid-preload returns the FSM to LOAD with `ld_count=0`. Memory retains the words already written.
- `reset` asserted in the same cycle as an access: the access is discarded, with no write and `sram_rdata=0` the next cycle.

## Test plan
- **Preload and fetch:** preload words 0..3 = 32'h11111111..44444444 with `ld_last` on word 3. Expect `ld_done=1` and `ld_count=4`. Then read 0xbfc00000, 0xbfc00004 and 0x9fc0000c on consecutive cycles; expect 32'h11111111, 32'h22222222, 32'h44444444 one cycle after each.
- **Byte write:** at hit index 5 holding 32'h12345678, write `wen=4'b0101`, `wdata=32'haabbccdd`. Expect `rdata`=32'h12345678 next cycle; a subsequent read returns 32'h12bb56dd.
- **Miss handling:** read 0x80000000 with default `BASE`. Expect `rdata=0`, `err_valid=1`, `err_addr=32'h80000000`, `err_cnt=1`. A following hit read returns memory data and leaves the error registers unchanged.
- **Arbitration:** hold `ld_valid=1` while `sram_en=1` for 3 cycles. Expect `ld_ready=0` and no preload write for those cycles. The word is accepted in the first cycle with `sram_en=0`.
- **Hold/reset:** after a read returns 32'hdeadbeef, drop `sram_en` for 4 cycles; expect `rdata` stays 32'hdeadbeef. Pulse `reset`; expect `rdata=0`, `ld_done=0`, `err_cnt=0`, and memory contents preserved on re-read.
